// File: rtl/spi_master.sv
// SPI master, mode 0 style (sclk idle low), LSB first, fixed word length.
// Each bit is a LOW half-period followed by a HIGH half-period of CLKDIV clocks.
module spi_master #(
    parameter int unsigned WIDTH  = 16,
    parameter int unsigned CLKDIV = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] txData,
    output logic [WIDTH-1:0] rxData,
    output logic             busy,
    output logic             done,
    output logic             sclk,
    output logic             cs,
    output logic             mosi,
    input  logic             miso
);

    localparam int unsigned DIV_W = (CLKDIV > 1) ? $clog2(CLKDIV) : 1;
    localparam int unsigned CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOW,
        ST_HIGH,
        ST_END
    } state_t;

    state_t             state_q, state_d;
    logic [DIV_W-1:0]   div_q, div_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   tx_q, tx_d;
    logic [WIDTH-1:0]   rx_q, rx_d;
    logic [WIDTH-1:0]   rx_data_d;
    logic               busy_d, done_d, sclk_d, cs_d, mosi_d;

    logic div_last, bit_last, accept, shift;

    // The done gate makes the cycle carrying the done pulse non-accepting.
    assign div_last = (div_q == DIV_W'(CLKDIV - 1));
    assign bit_last = (cnt_q == CNT_W'(WIDTH - 1));
    assign accept   = (state_q == ST_IDLE) && start && !done;
    assign shift    = (state_q == ST_HIGH) && div_last;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept)   state_d = ST_LOW;
            ST_LOW:  if (div_last) state_d = ST_HIGH;
            ST_HIGH: if (div_last) state_d = bit_last ? ST_END : ST_LOW;
            ST_END:  if (div_last) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    // Next values for the datapath and the registered outputs.
    always_comb begin
        div_d     = div_q;
        cnt_d     = cnt_q;
        tx_d      = tx_q;
        rx_d      = rx_q;
        rx_data_d = rxData;

        if (state_d != state_q) begin
            div_d = '0;
        end else if (state_q != ST_IDLE) begin
            div_d = div_q + DIV_W'(1);
        end

        if (accept) begin
            tx_d  = txData;
            cnt_d = '0;
        end else if (shift) begin
            tx_d  = tx_q >> 1;
            rx_d  = {miso, rx_q[WIDTH-1:1]};
            cnt_d = cnt_q + CNT_W'(1);
        end

        busy_d = (state_d != ST_IDLE);
        cs_d   = (state_d == ST_IDLE);
        sclk_d = (state_d == ST_HIGH);
        mosi_d = ((state_d == ST_LOW) || (state_d == ST_HIGH)) ? tx_d[0] : 1'b0;
        done_d = (state_q == ST_END) && div_last;
        if (done_d) begin
            rx_data_d = rx_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            div_q  <= '0;
            cnt_q  <= '0;
            tx_q   <= '0;
            rx_q   <= '0;
            rxData <= '0;
            busy   <= 1'b0;
            done   <= 1'b0;
            sclk   <= 1'b0;
            cs     <= 1'b1;
            mosi   <= 1'b0;
        end else begin
            div_q  <= div_d;
            cnt_q  <= cnt_d;
            tx_q   <= tx_d;
            rx_q   <= rx_d;
            rxData <= rx_data_d;
            busy   <= busy_d;
            done   <= done_d;
            sclk   <= sclk_d;
            cs     <= cs_d;
            mosi   <= mosi_d;
        end
    end

endmodule

// File: tb/tb_spi_master.sv
// Directed + randomized bench for spi_master (WIDTH=16, CLKDIV=2) with a
// loopback / scripted-peripheral model and word-level expected results.
module tb_spi_master;

    localparam int unsigned WIDTH   = 16;
    localparam int unsigned CLKDIV  = 2;
    localparam int          LATENCY = 1 + 2 * CLKDIV * WIDTH + CLKDIV;

    logic             clk = 1'b0;
    logic             reset = 1'b1;
    logic             start = 1'b0;
    logic [WIDTH-1:0] txData = '0;
    logic [WIDTH-1:0] rxData;
    logic             busy, done, sclk, cs, mosi, miso;

    logic             loopback = 1'b1;
    logic [WIDTH-1:0] pword = '0;

    int checks   = 0;
    int failures = 0;

    // Bus monitor / peripheral state, written only by the monitor process.
    logic             sclk_prev = 1'b0;
    logic             busy_prev = 1'b0;
    int               rises     = 0;
    int               cs_viol   = 0;
    logic [4:0]       pidx      = '0;
    logic [WIDTH-1:0] mosi_cap  = '0;

    spi_master #(.WIDTH(WIDTH), .CLKDIV(CLKDIV)) dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .txData (txData),
        .rxData (rxData),
        .busy   (busy),
        .done   (done),
        .sclk   (sclk),
        .cs     (cs),
        .mosi   (mosi),
        .miso   (miso)
    );

    always #5 clk = ~clk;

    // Peripheral presents bit pidx of its word; it advances after each sclk fall.
    assign miso = loopback ? mosi : pword[pidx[3:0]];

    always @(posedge clk) begin
        sclk_prev <= sclk;
        busy_prev <= busy;
        if (busy && !busy_prev) begin
            rises <= 0;
            pidx  <= '0;
        end else begin
            if (sclk && !sclk_prev) begin
                rises    <= rises + 1;
                mosi_cap <= {mosi, mosi_cap[WIDTH-1:1]};
            end
            if (!sclk && sclk_prev) pidx <= pidx + 5'd1;
        end
        if (busy && cs) cs_viol <= cs_viol + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One full transfer; txData is scrambled every cycle after acceptance and a
    // stray start is pulsed mid-transfer, neither of which may affect the result.
    task automatic run_xfer(input logic [WIDTH-1:0] tx, input logic lb, input logic [WIDTH-1:0] pw);
        logic [WIDTH-1:0] exp_rx, prev_rx;
        int lat;
        bit hold_bad;
        exp_rx = lb ? tx : pw;
        repeat (2) @(posedge clk);
        #1;
        prev_rx  = rxData;
        loopback = lb;
        pword    = pw;
        txData   = tx;
        start    = 1'b1;
        @(posedge clk);
        #1;
        start    = 1'b0;
        lat      = 1;
        hold_bad = 1'b0;
        chk("accept_busy", 32'(busy), 32'd1);
        chk("accept_cs", 32'(cs), 32'd0);
        while (!done && lat < 200) begin
            txData = WIDTH'($urandom);
            start  = (lat == 20);
            @(posedge clk);
            #1;
            lat++;
            if (!done && rxData !== prev_rx) hold_bad = 1'b1;
        end
        start = 1'b0;
        chk("latency", 32'(lat), 32'(LATENCY));
        chk("rx_word", 32'(rxData), 32'(exp_rx));
        chk("sclk_rises", 32'(rises), 32'(WIDTH));
        chk("mosi_seq", 32'(mosi_cap), 32'(tx));
        chk("cs_low_while_busy", 32'(cs_viol), 32'd0);
        chk("rx_hold_during", 32'(hold_bad), 32'd0);
        chk("done_busy", 32'(busy), 32'd0);
        chk("done_cs", 32'(cs), 32'd1);
        @(posedge clk);
        #1;
        chk("done_one_cycle", 32'(done), 32'd0);
        chk("no_queued_start", 32'(busy), 32'd0);
        @(posedge clk);
        #1;
        chk("rx_hold_after", 32'(rxData), 32'(exp_rx));
    endtask

    initial begin
        int nd, gap, maxgap, n;
        logic [WIDTH-1:0] prev_rx;

        // Reset with start held high: reset must win.
        reset  = 1'b1;
        start  = 1'b1;
        txData = 16'hFFFF;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_cs", 32'(cs), 32'd1);
        chk("rst_sclk", 32'(sclk), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_mosi", 32'(mosi), 32'd0);
        chk("rst_rxdata", 32'(rxData), 32'd0);
        reset = 1'b0;
        start = 1'b0;

        run_xfer(16'h00A5, 1'b1, 16'h0000);
        run_xfer(16'h1234, 1'b0, 16'hBEEF);
        for (int i = 0; i < 6; i++) begin
            run_xfer(WIDTH'($urandom), (i % 2) == 0, WIDTH'($urandom));
        end

        // Reset at cycle 30 of a transfer aborts it cleanly.
        repeat (2) @(posedge clk);
        #1;
        prev_rx  = rxData;
        loopback = 1'b1;
        txData   = WIDTH'($urandom);
        start    = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 1;
        while (n < 30) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("pre_abort_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        chk("abort_cs", 32'(cs), 32'd1);
        chk("abort_sclk", 32'(sclk), 32'd0);
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_rx_zero", 32'(rxData), 32'd0);
        nd = 0;
        repeat (100) begin
            @(posedge clk);
            #1;
            if (done) nd++;
        end
        chk("abort_no_done", 32'(nd), 32'd0);
        run_xfer(WIDTH'($urandom), 1'b1, 16'h0000);

        // start held high for 200 cycles: two completions, cs gap between them.
        repeat (2) @(posedge clk);
        #1;
        loopback = 1'b1;
        txData   = WIDTH'($urandom);
        start    = 1'b1;
        nd = 0;
        gap = 0;
        maxgap = 0;
        for (int c = 0; c < 200; c++) begin
            @(posedge clk);
            #1;
            if (done) nd++;
            if (cs) begin
                gap++;
            end else begin
                if (gap > maxgap) maxgap = gap;
                gap = 0;
            end
        end
        start = 1'b0;
        chk("held_start_dones", 32'(nd), 32'd2);
        chk("held_start_cs_gap", 32'(maxgap >= 1), 32'd1);
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("held_start_drain", 32'(busy), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
